// File: rtl/message_pkg.sv
// Shared types and constants for the message player: FSM encoding, default
// message ROM contents and default hold time.
package message_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int MSG_LEN_DEF = 16;
  localparam int CHAR_W_DEF  = 8;
  localparam int HOLD_W_DEF  = 24;

  // Entry 0 sits in the most significant character slot.
  localparam logic [MSG_LEN_DEF*CHAR_W_DEF-1:0] MSG_ROM = "SOY DE ZACAPA   ";

  localparam logic [HOLD_W_DEF-1:0] DEFAULT_HOLD = 24'd12_000_000;

  localparam logic [7:0] CHAR_BLANK = 8'h20;

endpackage

// File: rtl/message_player_if.sv
// Control and display signals between the ui_in decode and the message player.
interface message_player_if #(
  parameter int CHAR_W = 8,
  parameter int HOLD_W = 24,
  parameter int IDX_W  = 4
) ();

  logic              ena;
  logic              start;
  logic              mode_loop;
  logic              pause;
  logic [HOLD_W-1:0] hold_cycles;

  logic [CHAR_W-1:0] char_out;
  logic              char_valid;
  logic [IDX_W-1:0]  index_out;
  logic              busy;
  logic              done;

  modport master (
    output ena, start, mode_loop, pause, hold_cycles,
    input  char_out, char_valid, index_out, busy, done
  );

  modport slave (
    input  ena, start, mode_loop, pause, hold_cycles,
    output char_out, char_valid, index_out, busy, done
  );

endinterface

// File: rtl/message_rom.sv
// Combinational character lookup into a packed message ROM; entry 0 is the
// most significant character. Unpopulated indices read back as a blank.
module message_rom
  import message_pkg::*;
#(
  parameter int                          MSG_LEN  = 16,
  parameter int                          CHAR_W   = 8,
  parameter int                          IDX_W    = 4,
  parameter logic [MSG_LEN*CHAR_W-1:0]   ROM_INIT = '0
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [CHAR_W-1:0] ch
);

  always_comb begin
    ch = CHAR_W'(CHAR_BLANK);
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == IDX_W'(i)) begin
        ch = ROM_INIT[(MSG_LEN-1-i)*CHAR_W +: CHAR_W];
      end
    end
  end

endmodule

// File: rtl/message_player.sv
// Steps through a fixed character ROM, holding each character for a
// programmable number of cycles, with one-shot/loop, pause and restart.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | after reset, nothing played yet; outputs hold
//   ST_PLAY   | hold counter running, advancing on expiry
//   ST_PAUSED | counter and outputs frozen while pause is high
//   ST_DONE   | one-shot finished; last character stays displayed
module message_player
  import message_pkg::*;
#(
  parameter int                        MSG_LEN  = MSG_LEN_DEF,
  parameter int                        CHAR_W   = CHAR_W_DEF,
  parameter int                        HOLD_W   = HOLD_W_DEF,
  parameter logic [MSG_LEN*CHAR_W-1:0] ROM_INIT = MSG_ROM
) (
  input logic             clk,
  input logic             rst_n,
  message_player_if.slave bus
);

  localparam int               IDX_W    = $clog2(MSG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic                valid_q, valid_d;

  logic [HOLD_W-1:0]   reload;
  logic [IDX_W-1:0]    load_idx;
  logic [CHAR_W-1:0]   load_char;

  // A hold of zero behaves as one cycle per character.
  assign reload = (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - HOLD_W'(1);

  // The only index ever loaded is either 0 (start / wrap) or the successor.
  assign load_idx = (bus.start || idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  message_rom #(
    .MSG_LEN  (MSG_LEN),
    .CHAR_W   (CHAR_W),
    .IDX_W    (IDX_W),
    .ROM_INIT (ROM_INIT)
  ) u_rom (
    .idx (load_idx),
    .ch  (load_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    char_d  = char_q;
    valid_d = 1'b0;

    if (!bus.ena) begin
      valid_d = 1'b0;
    end else if (bus.start) begin
      state_d = ST_PLAY;
      idx_d   = load_idx;
      char_d  = load_char;
      cnt_d   = reload;
      valid_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLAY, ST_PAUSED: begin
          if (bus.pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_PLAY;
            if (cnt_q != '0) begin
              cnt_d = cnt_q - HOLD_W'(1);
            end else if (idx_q == LAST_IDX && !bus.mode_loop) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = load_idx;
              char_d  = load_char;
              cnt_d   = reload;
              valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign bus.char_out   = char_q;
  assign bus.char_valid = valid_q;
  assign bus.index_out  = idx_q;
  assign bus.busy       = (state_q == ST_PLAY) || (state_q == ST_PAUSED);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_message_player.sv
// Scoreboard bench for message_player with a 4-entry ROM (5A 41 43 41).
module tb_message_player;

  localparam int          MSG_LEN = 4;
  localparam int          CHAR_W  = 8;
  localparam int          HOLD_W  = 24;
  localparam int          IDX_W   = 2;
  localparam logic [31:0] ROM     = 32'h5A41_4341;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  message_player_if #(.CHAR_W(CHAR_W), .HOLD_W(HOLD_W), .IDX_W(IDX_W)) bus ();

  message_player #(
    .MSG_LEN  (MSG_LEN),
    .CHAR_W   (CHAR_W),
    .HOLD_W   (HOLD_W),
    .ROM_INIT (ROM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                rel;
    logic [IDX_W-1:0]  idx;
    logic [CHAR_W-1:0] ch;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   start_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int rel, input int idx, input logic [7:0] ch);
    exp_t e;
    e.rel = rel;
    e.idx = IDX_W'(idx);
    e.ch  = ch;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge where the new run is at rel 0.
  task automatic issue_start();
    bus.start  = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic to_rel(input int r);
    int guard = 0;
    while ((cyc - start_edge) < r && guard < 500) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Monitor: every char_valid strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.char_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got char 'h%0h idx %0d expected no strobe (cycle %0d)",
                   bus.char_out, bus.index_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_timing", 32'(cyc - start_edge), 32'(e.rel));
          chk("strobe_index", 32'(bus.index_out), 32'(e.idx));
          chk("strobe_char", 32'(bus.char_out), 32'(e.ch));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena         = 1'b0;
    bus.start       = 1'b0;
    bus.mode_loop   = 1'b0;
    bus.pause       = 1'b0;
    bus.hold_cycles = '0;
    repeat (3) @(negedge clk);
    chk("rst_char", 32'(bus.char_out), 32'h0);
    chk("rst_valid", 32'(bus.char_valid), 32'h0);
    chk("rst_index", 32'(bus.index_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    rst_n   = 1'b1;
    bus.ena = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'h0);
    chk("idle_char", 32'(bus.char_out), 32'h0);

    // One-shot, hold 3
    bus.hold_cycles = 24'd3;
    bus.mode_loop   = 1'b0;
    push(0, 0, 8'h5A); push(3, 1, 8'h41); push(6, 2, 8'h43); push(9, 3, 8'h41);
    issue_start();
    chk("os_valid0", 32'(bus.char_valid), 32'h1);
    chk("os_busy0", 32'(bus.busy), 32'h1);
    to_rel(11);
    chk("os_done_early", 32'(bus.done), 32'h0);
    to_rel(12);
    chk("os_done", 32'(bus.done), 32'h1);
    chk("os_busy_end", 32'(bus.busy), 32'h0);
    chk("os_char_end", 32'(bus.char_out), 32'h41);
    chk("os_index_end", 32'(bus.index_out), 32'h3);
    to_rel(16);
    chk("os_char_hold", 32'(bus.char_out), 32'h41);
    chk("os_done_hold", 32'(bus.done), 32'h1);

    // Loop with hold 0, then drop to one-shot mid-pass
    bus.hold_cycles = 24'd0;
    bus.mode_loop   = 1'b1;
    push(0, 0, 8'h5A); push(1, 1, 8'h41); push(2, 2, 8'h43); push(3, 3, 8'h41);
    push(4, 0, 8'h5A); push(5, 1, 8'h41); push(6, 2, 8'h43); push(7, 3, 8'h41);
    issue_start();
    for (int r = 0; r < 6; r++) begin
      to_rel(r);
      chk("loop_valid", 32'(bus.char_valid), 32'h1);
      chk("loop_done", 32'(bus.done), 32'h0);
      chk("loop_index", 32'(bus.index_out), 32'(r % 4));
    end
    bus.mode_loop = 1'b0;
    to_rel(8);
    chk("loop_stop_done", 32'(bus.done), 32'h1);
    chk("loop_stop_char", 32'(bus.char_out), 32'h41);

    // Pause for 4 cycles with one cycle of count left after the current one
    bus.hold_cycles = 24'd5;
    push(0, 0, 8'h5A); push(9, 1, 8'h41); push(14, 2, 8'h43); push(19, 3, 8'h41);
    issue_start();
    to_rel(3);
    bus.pause = 1'b1;
    for (int r = 4; r < 8; r++) begin
      to_rel(r);
      chk("pause_index", 32'(bus.index_out), 32'h0);
      chk("pause_busy", 32'(bus.busy), 32'h1);
    end
    bus.pause = 1'b0;
    to_rel(8);
    chk("resume_index", 32'(bus.index_out), 32'h0);
    chk("resume_valid", 32'(bus.char_valid), 32'h0);
    to_rel(9);
    chk("resume_adv", 32'(bus.index_out), 32'h1);
    to_rel(23);
    chk("pause_done_early", 32'(bus.done), 32'h0);
    to_rel(24);
    chk("pause_done", 32'(bus.done), 32'h1);

    // Same timing with ena low for 4 cycles; a start during the freeze is dropped
    push(0, 0, 8'h5A); push(9, 1, 8'h41); push(14, 2, 8'h43); push(19, 3, 8'h41);
    issue_start();
    to_rel(3);
    bus.ena = 1'b0;
    for (int r = 4; r < 8; r++) begin
      to_rel(r);
      bus.start = (r == 4);
      chk("ena_index", 32'(bus.index_out), 32'h0);
      chk("ena_busy", 32'(bus.busy), 32'h1);
    end
    bus.ena = 1'b1;
    to_rel(8);
    chk("ena_resume_index", 32'(bus.index_out), 32'h0);
    to_rel(9);
    chk("ena_adv", 32'(bus.index_out), 32'h1);
    to_rel(24);
    chk("ena_done", 32'(bus.done), 32'h1);

    // Restart on the expiry cycle at index 2, with pause also high
    bus.hold_cycles = 24'd3;
    push(0, 0, 8'h5A); push(3, 1, 8'h41); push(6, 2, 8'h43);
    issue_start();
    to_rel(8);
    chk("rs_pre_index", 32'(bus.index_out), 32'h2);
    push(0, 0, 8'h5A); push(3, 1, 8'h41);
    bus.pause = 1'b1;
    issue_start();
    bus.pause = 1'b0;
    chk("rs_valid", 32'(bus.char_valid), 32'h1);
    chk("rs_index", 32'(bus.index_out), 32'h0);
    chk("rs_char", 32'(bus.char_out), 32'h5A);
    chk("rs_busy", 32'(bus.busy), 32'h1);

    // Reset in the middle of playback
    to_rel(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_char", 32'(bus.char_out), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    chk("midrst_index", 32'(bus.index_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'h0);
    chk("post_rst_char", 32'(bus.char_out), 32'h0);
    chk("post_rst_index", 32'(bus.index_out), 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/message_player.md
Name: message_player

Overview:
- Parametrised successor to the single-character display driver.
- Steps through a fixed character ROM of MSG_LEN entries and presents one character at a time on the 7-segment/char output.
- Each character is held for a programmable number of cycles; one-shot and loop modes, pause and restart.
- Sits between the top-level ui_in decoding and uo_out in the tt_um wrapper.

Parameters:
- MSG_LEN, 16: number of characters in the message ROM, minimum 2.
- CHAR_W, 8: width of one character code.
- HOLD_W, 24: width of the per-character hold count.
- IDX_W, $clog2(MSG_LEN): width of the index; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; low freezes all state
- start  in  1  one-cycle pulse; (re)starts playback at index 0
- mode_loop  in  1  1 = wrap to index 0 after the last char; 0 = stop after the last char
- pause  in  1  level; holds the current char and hold count
- hold_cycles  in  HOLD_W  cycles each char is displayed; 0 is treated as 1
- char_out  out  CHAR_W  current character code, registered
- char_valid  out  1  one-cycle strobe on the cycle char_out changes to a new entry
- index_out  out  IDX_W  index of the char currently on char_out
- busy  out  1  high in PLAY or PAUSED
- done  out  1  high in DONE (one-shot completed)

Behaviour:
- Reset (async, rst_n=0): state IDLE; char_out=0, char_valid=0, index_out=0, busy=0, done=0, hold counter=0.
- States: IDLE, PLAY, PAUSED, DONE. Encoding lives in the package.
- ena=0: no state, counter, index or output register changes. char_valid is forced 0 that cycle. start is ignored, not queued.
- start=1 with ena=1, from any state:
  - next cycle: state=PLAY, index=0, char_out=ROM[0], char_valid=1.
  - hold counter loads max(hold_cycles,1)-1.
  - Latency start->char_valid is 1 cycle.
  - start has priority over pause and over hold expiry in the same cycle.
- PLAY, pause=0: counter decrements each cycle.
  - Expiry (counter==0) with index<MSG_LEN-1: index+1, char_out=ROM[index+1], char_valid=1, counter reloads.
  - Each char is therefore visible exactly max(hold_cycles,1) cycles.
- PLAY, expiry with index==MSG_LEN-1:
  - mode_loop=1: index=0, char_out=ROM[0], char_valid=1, stay PLAY.
  - mode_loop=0: state=DONE, char_out holds the last char, char_valid=0, done=1, busy=0.
- PLAY, pause=1 (no start): next state PAUSED; counter and outputs frozen.
  - If pause rises on an expiry cycle, the advance is suppressed; it happens after resume.
- PAUSED, pause=0: return to PLAY and continue the remaining count. No char_valid on resume.
- IDLE/DONE: outputs hold; only start leaves these states.
- hold_cycles and mode_loop are sampled only at each reload / expiry decision. Mid-character changes take effect on the next char.
- Index arithmetic is IDX_W-bit. Wrap is explicit at MSG_LEN-1, never by overflow.
- Reset mid-playback returns immediately to the reset values above.

Decomposition:
- Package message_pkg holds:
  - state enum (IDLE/PLAY/PAUSED/DONE);
  - MSG_ROM constant array of CHAR_W codes, default "SOY DE ZACAPA   ";
  - DEFAULT_HOLD constant.
- Sub-module message_rom: combinational lookup, index -> char, reading MSG_ROM. Out-of-range index returns 8'h20.
- message_player holds the FSM, hold counter and index register.

Test Plan:
- Reset mid-run: assert rst_n=0 during PLAY -> same cycle char_out=0, busy=0, done=0, index_out=0. After release, stays IDLE.
- One-shot playback: MSG_LEN=4, ROM 5A 41 43 41, hold_cycles=3, mode_loop=0, start pulse:
  - chars 5A,41,43,41, each held 3 cycles;
  - char_valid exactly 4 pulses, 3 cycles apart;
  - done=1 on cycle 13 after start, char_out stays 41.
- Loop plus hold zero: same ROM, mode_loop=1, hold_cycles=0:
  - char changes every cycle, index sequence 0,1,2,3,0,1;
  - char_valid continuously 1; done never set.
- Pause and ena freeze: hold_cycles=5, pause for 4 cycles at count 2 remaining -> index_out unchanged for 4 cycles, then advances exactly 2 cycles after pause drops. Same check with ena=0 for 4 cycles gives identical timing.
- Restart priority: start asserted on the same cycle as an expiry at index 2 -> next cycle index_out=0, char_out=5A, char_valid=1, state PLAY.
